// File: rtl/inv_arb_pkg.sv
// rtl/inv_arb_pkg.sv - shared types and constants for the inverse-core arbiter
// Contents: FSM state enum, field prime, default operand width.
package inv_arb_pkg;

  localparam int INV_WIDTH_DEFAULT = 255;

  // p = 2^255 - 19
  localparam logic [254:0] FIELD_P = {{247{1'b1}}, 8'hED};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } inv_state_e;

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin picker
// Ports:
//   req        request vector
//   ptr        index searched first; search wraps modulo NUM_REQ
//   grant_oh   one-hot grant (all zero when nothing requested)
//   grant_idx  index of the granted request
//   any        at least one request present
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  logic [IDW-1:0] sel;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[sel]) begin
        any           = 1'b1;
        grant_idx     = sel;
        grant_oh[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inv_arbiter.sv
// rtl/inv_arbiter.sv - round-robin arbiter sharing one modular-inverse core
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_req_valid/i_req_x/o_req_ready   per-requester operand handshake
//   o_rsp_valid/o_rsp_id/o_rsp_data   tagged response, held until i_rsp_ready
//   o_core_start/o_core_x             start pulse and held operand to the core
//   i_core_result/i_core_finished     core result and its one-cycle strobe
//   o_busy                            high whenever not idle
// Macro INV_ZERO_BYPASS_EN: zero operands skip the core and answer 0.
module inv_arbiter
  import inv_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = INV_WIDTH_DEFAULT
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   i_req_x,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic                            o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      o_rsp_id,
  output logic [WIDTH-1:0]                o_rsp_data,
  input  logic                            i_rsp_ready,
  output logic                            o_core_start,
  output logic [WIDTH-1:0]                o_core_x,
  input  logic [WIDTH-1:0]                i_core_result,
  input  logic                            i_core_finished,
  output logic                            o_busy
);

  localparam int IDW = $clog2(NUM_REQ);

  inv_state_e      state, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [WIDTH-1:0] op_r, data_r;
  logic [IDW-1:0]  id_r;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [WIDTH-1:0]   sel_x;
  logic               accept;

  rr_grant #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_grant (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign sel_x  = i_req_x[grant_idx];
  // ready is only ever offered to a valid requester, so any offer is a handshake
  assign accept = (state == ST_IDLE) && grant_any;

  always_comb begin
    state_d      = state;
    o_req_ready  = '0;
    o_core_start = 1'b0;
    o_rsp_valid  = 1'b0;
    o_busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        o_req_ready = grant_oh;
        if (grant_any) begin
`ifdef INV_ZERO_BYPASS_EN
          state_d = (sel_x == '0) ? ST_RESP : ST_LAUNCH;
`else
          state_d = ST_LAUNCH;
`endif
        end
      end
      ST_LAUNCH: begin
        o_core_start = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_core_finished) state_d = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      op_r   <= '0;
      id_r   <= '0;
      data_r <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_r   <= sel_x;
        id_r   <= grant_idx;
        rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef INV_ZERO_BYPASS_EN
        if (sel_x == '0) data_r <= '0;
`endif
      end
      // core result is only meaningful during its strobe
      if (state == ST_WAIT && i_core_finished) data_r <= i_core_result;
    end
  end

  // op_r stays put from LAUNCH through WAIT, so the core sees a stable operand
  assign o_core_x   = op_r;
  assign o_rsp_id   = id_r;
  assign o_rsp_data = data_r;

endmodule

// File: doc/inv_arbiter.md
# inv_arbiter

Shares one modular-inverse core (field prime p = 2^255 − 19) between several requesters in the point-arithmetic datapath. Requesters post operands over a valid/ready handshake. The arbiter grants them round-robin, pulses the core's start input and waits for the core's one-cycle finished strobe. It then returns the captured result, tagged with the requester index, over a valid/ready response channel. It sits between the scalar-multiplication controllers and the single inverse core instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 255, operand/result width in bits
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  NUM_REQ  per-requester operand valid
- i_req_x  in  NUM_REQ×WIDTH  per-requester operand
- o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- o_rsp_valid  out  1  response valid
- o_rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response
- o_rsp_data  out  WIDTH  inverse result
- i_rsp_ready  in  1  response consumer ready
- o_core_start  out  1  one-cycle start pulse to the inverse core
- o_core_x  out  WIDTH  operand to the core, held stable from start until finished
- i_core_result  in  WIDTH  core result, valid only while i_core_finished is high
- i_core_finished  in  1  one-cycle completion strobe from the core
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - grant g = first index with i_req_valid set, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - o_req_ready[g] = 1 combinationally; all other ready bits are 0; no requester valid → all 0.
  - On valid&ready: latch x → op_r, latch g → id_r, set rr_ptr = (g+1) mod NUM_REQ, go to LAUNCH.
- LAUNCH: o_core_start = 1 for exactly this cycle; o_core_x = op_r; go to WAIT.
- WAIT: o_core_x holds op_r. On i_core_finished: latch i_core_result → data_r, go to RESP. The result is sampled only in the strobe cycle.
- RESP: o_rsp_valid = 1, o_rsp_id = id_r, o_rsp_data = data_r. Data and id stay stable until i_rsp_ready. On i_rsp_ready go to IDLE.
- A new grant happens no earlier than the IDLE cycle after the response handshake. The core is never restarted while busy.
- i_core_finished in IDLE, LAUNCH or RESP: ignored.
- Requester valid deasserted before grant: no effect; the arbiter holds no pending state per requester.
- Reset (any state, asynchronous): state = IDLE, rr_ptr = 0, op_r/id_r/data_r = 0. The core is reset by the same system reset.
- Reset values of outputs: o_req_ready = 0, o_rsp_valid = 0, o_rsp_id = 0, o_rsp_data = 0, o_core_start = 0, o_core_x = 0, o_busy = 0.

## Timing
- Accept at cycle T. Start pulse at T+1. Core strobe at T+1+L, where L is the core latency. o_rsp_valid from T+2+L.
- Minimum period between consecutive grants: L+3 cycles with i_rsp_ready tied high.
- All outputs except o_req_ready are registered or decoded from registered state. o_req_ready depends combinationally on i_req_valid and rr_ptr.

## Configuration
- INV_ZERO_BYPASS_EN defined:
  - An accepted operand equal to 0 goes IDLE → RESP directly, with o_rsp_data = 0.
  - No start pulse is issued and the core is untouched.
  - Response appears at T+1.
- INV_ZERO_BYPASS_EN undefined: zero operands follow the normal LAUNCH/WAIT path, and the arbiter forwards whatever the core returns.

## Structure
- Package inv_arb_pkg holds:
  - the state enum typedef
  - the FIELD_P localparam (2^255 − 19)
  - the default WIDTH
- Sub-module rr_grant: a combinational round-robin picker. Inputs: request vector, pointer. Outputs: one-hot grant, grant index, any-valid flag. Instantiated once.

## Test plan
Core bench model: fixed L = 20; result = x XOR 255'h5A.
- Single request, requester 2, x = 7: start pulse at T+1 with o_core_x = 7; o_rsp_valid at T+22 with id = 2, data = 7^0x5A.
- Requesters 0 and 3 both valid from reset: 0 is served first, then 3. rr_ptr reads 1, then 0.
- Back-pressure: i_rsp_ready held low 10 cycles in RESP. Data and id stay stable and no new grant occurs. A single response handshake happens when ready rises.
- Async reset asserted mid-WAIT (cycle T+10): all outputs return to reset values immediately. A later request from requester 1 is served from rr_ptr = 0.
- Zero operand from requester 1, macro defined: no o_core_start; response at T+1 with data = 0. Macro undefined: start pulse issued; response at T+22 with data = 0x5A.
- All four requesters valid continuously for 8 transactions: grant order 0,1,2,3,0,1,2,3. Exactly one o_core_start per transaction.
